// File: rtl/queue_tx.sv
`default_nettype none
// =============================================================================
// queue_tx : drains a word queue onto a serial line (start, QW data LSB first, stop)
// Rev 1.0
// =============================================================================
module queue_tx #(
    parameter int QW      = 4,
    parameter int BIT_CYC = 16
) (
    input  logic          clk100,
    input  logic          rst_n,
    input  logic          en,
    input  logic          q_empty,
    input  logic [QW-1:0] q_data,
    output logic          q_pop,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic [7:0]    sent_cnt
);

    localparam int c_bw = $clog2(QW + 1);
    localparam logic [7:0]      c_cyc_last = 8'(BIT_CYC - 1);
    localparam logic [c_bw-1:0] c_bit_last = c_bw'(QW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [QW-1:0]   r_shift;
    logic [7:0]      r_cyc;
    logic [c_bw-1:0] r_bit;

    logic            w_cyc_last;
    logic            w_bit_last;
    logic [QW-1:0]   w_shift_nxt;

    assign w_cyc_last  = (r_cyc == c_cyc_last);
    assign w_bit_last  = (r_bit == c_bit_last);
    assign w_shift_nxt = r_shift >> 1;

    // q_data is captured only on the launch edge; the queue may change freely afterwards
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cyc    <= '0;
            r_bit    <= '0;
            q_pop    <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            sent_cnt <= '0;
        end else begin
            q_pop <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (en && !q_empty) begin
                        r_shift <= q_data;
                        q_pop   <= 1'b1;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_cyc_last) begin
                        r_cyc   <= '0;
                        tx      <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_cyc_last) begin
                        r_cyc <= '0;
                        if (w_bit_last) begin
                            tx      <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift <= w_shift_nxt;
                            tx      <= w_shift_nxt[0];
                            r_bit   <= r_bit + c_bw'(1);
                        end
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                S_STOP: begin
                    if (w_cyc_last) begin
                        r_cyc    <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sent_cnt <= sent_cnt + 8'd1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_queue_tx.sv
`default_nettype none
// =============================================================================
// tb_queue_tx : scoreboard bench for queue_tx (default timing plus a BIT_CYC=2 instance)
// Rev 1.0
// =============================================================================
module tb_queue_tx;

    localparam int QW = 4;
    localparam int BC = 16;

    logic          clk100 = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b0;
    logic          q_empty;
    logic [QW-1:0] q_data;
    logic          q_pop, tx, busy, done;
    logic [7:0]    sent_cnt;

    logic          en2      = 1'b0;
    logic          q_empty2 = 1'b1;
    logic [QW-1:0] q_data2  = 4'h6;
    logic          q_pop2, tx2, busy2, done2;
    logic [7:0]    sent_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int pop_cnt = 0, done_cnt = 0, pop_long = 0;
    logic prev_pop = 1'b0;
    int pop_cyc[$];
    int done_cyc[$];

    logic [QW-1:0] qm[$];
    logic [QW-1:0] sb[$];
    logic          mon_armed = 1'b1;
    logic [QW-1:0] mon_w;

    queue_tx #(.QW(QW), .BIT_CYC(BC)) dut (
        .clk100(clk100), .rst_n(rst_n), .en(en), .q_empty(q_empty), .q_data(q_data),
        .q_pop(q_pop), .tx(tx), .busy(busy), .done(done), .sent_cnt(sent_cnt)
    );

    queue_tx #(.QW(QW), .BIT_CYC(2)) dut2 (
        .clk100(clk100), .rst_n(rst_n), .en(en2), .q_empty(q_empty2), .q_data(q_data2),
        .q_pop(q_pop2), .tx(tx2), .busy(busy2), .done(done2), .sent_cnt(sent_cnt2)
    );

    always #5 clk100 = ~clk100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk100);
        cyc++;
    end

    // Queue model: pops on the strobe, hands the popped word to the scoreboard
    initial begin
        q_empty = 1'b1;
        q_data  = '0;
        forever begin
            @(negedge clk100);
            if (q_pop === 1'b1 && qm.size() > 0) begin
                if (mon_armed) sb.push_back(qm[0]);
                qm.delete(0);
            end
            q_empty = (qm.size() == 0);
            q_data  = (qm.size() > 0) ? qm[0] : '0;
        end
    end

    initial forever begin
        @(negedge clk100);
        if (q_pop === 1'b1) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            if (prev_pop) pop_long++;
        end
        prev_pop = q_pop;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
    end

    // Serial monitor: samples mid-bit and compares the word against the scoreboard
    initial forever begin
        @(negedge clk100);
        if (mon_armed && rst_n && tx === 1'b0) begin
            repeat (BC / 2) @(negedge clk100);
            check_eq("start_bit", {31'd0, tx}, 32'd0);
            for (int i = 0; i < QW; i++) begin
                repeat (BC) @(negedge clk100);
                mon_w[i] = tx;
            end
            repeat (BC) @(negedge clk100);
            check_eq("stop_bit", {31'd0, tx}, 32'd1);
            if (sb.size() == 0) begin
                check_eq("sb_avail", 32'(sb.size()), 32'd1);
            end else begin
                check_eq("frame_data", 32'(mon_w), 32'(sb.pop_front()));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk100);
        rst_n = 1'b0;
        repeat (3) @(negedge clk100);
        pop_cyc.delete();
        done_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int target, input int limit, input string tag);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk100);
            n++;
        end
        @(negedge clk100);
        if (done_cnt < target) check_eq(tag, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_pop(input int target, input int limit, input string tag);
        int n = 0;
        while (pop_cnt < target && n < limit) begin
            @(negedge clk100);
            n++;
        end
        if (pop_cnt < target) check_eq(tag, 32'(pop_cnt), 32'(target));
    endtask

    initial begin
        int base, dbase, viol, n2, guard;

        // Reset state
        repeat (3) @(negedge clk100);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_pop", {31'd0, q_pop}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_cnt", 32'(sent_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk100);

        // Single frame 0xA
        base = pop_cnt; dbase = done_cnt;
        qm.push_back(4'hA);
        en = 1'b1;
        wait_done(dbase + 1, 300, "t1_timeout");
        check_eq("t1_pops", 32'(pop_cnt - base), 32'd1);
        check_eq("t1_pop_width", 32'(pop_long), 32'd0);
        if (pop_cyc.size() > 0 && done_cyc.size() > 0)
            check_eq("t1_len", 32'(done_cyc[$] - pop_cyc[$]), 32'd96);
        check_eq("t1_cnt", 32'(sent_cnt), 32'd1);
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        en = 1'b0;

        // Three back-to-back words
        do_reset();
        @(negedge clk100);
        dbase = done_cnt;
        qm.push_back(4'h3); qm.push_back(4'hC); qm.push_back(4'h5);
        en = 1'b1;
        wait_done(dbase + 3, 600, "t2_timeout");
        check_eq("t2_pops", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3) begin
            check_eq("t2_space0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd97);
            check_eq("t2_space1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd97);
        end
        check_eq("t2_cnt", 32'(sent_cnt), 32'd3);

        // Empty queue with enable held
        viol = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk100);
            if (tx !== 1'b1 || q_pop !== 1'b0 || busy !== 1'b0) viol++;
        end
        check_eq("t3_idle_viol", 32'(viol), 32'd0);

        // Enable dropped mid-frame
        base = pop_cnt; dbase = done_cnt;
        qm.push_back(4'h7); qm.push_back(4'h2);
        wait_pop(base + 1, 50, "t4_pop_timeout");
        repeat (30) @(negedge clk100);
        en = 1'b0;
        wait_done(dbase + 1, 200, "t4_timeout");
        if (pop_cyc.size() > 0 && done_cyc.size() > 0)
            check_eq("t4_len", 32'(done_cyc[$] - pop_cyc[$]), 32'd96);
        repeat (200) @(negedge clk100);
        check_eq("t4_no_pop", 32'(pop_cnt - base), 32'd1);
        check_eq("t4_idle_tx", {31'd0, tx}, 32'd1);
        check_eq("t4_cnt", 32'(sent_cnt), 32'd4);
        qm.delete();
        @(negedge clk100);

        // Asynchronous reset mid-frame
        mon_armed = 1'b0;
        base = pop_cnt;
        qm.push_back(4'hE);
        en = 1'b1;
        wait_pop(base + 1, 50, "t5_pop_timeout");
        repeat (40) @(negedge clk100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_tx", {31'd0, tx}, 32'd1);
        check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_rst_cnt", 32'(sent_cnt), 32'd0);
        qm.push_back(4'h9);
        @(negedge clk100);
        #2 rst_n = 1'b1;
        @(posedge clk100);
        #1;
        check_eq("t5_first_pop", {31'd0, q_pop}, 32'd1);
        check_eq("t5_first_tx", {31'd0, tx}, 32'd0);
        dbase = done_cnt;
        wait_done(dbase + 1, 200, "t5_timeout");
        check_eq("t5_cnt", 32'(sent_cnt), 32'd1);
        en = 1'b0;

        // 256 frames at BIT_CYC=2
        @(negedge clk100);
        en2 = 1'b1; q_empty2 = 1'b0;
        n2 = 0; guard = 0;
        while (n2 < 256 && guard < 256 * 13 + 100) begin
            @(negedge clk100);
            guard++;
            if (done2 === 1'b1) begin
                n2++;
                if (n2 == 255) check_eq("t6_cnt_255", 32'(sent_cnt2), 32'd255);
            end
        end
        q_empty2 = 1'b1;
        check_eq("t6_dones", 32'(n2), 32'd256);
        check_eq("t6_wrap", 32'(sent_cnt2), 32'd0);
        repeat (20) @(negedge clk100);
        check_eq("t6_idle_busy", {31'd0, busy2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
